// File: rtl/spi_slave.sv
// SPI mode-0 target: oversamples SCK/NSS/MOSI in clk_i, deserialises MOSI into an
// RX FIFO and serialises TX FIFO bytes onto MISO, MSB first, 8-bit frames.
module spi_slave #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          spi_sck_i,
    input  logic                          spi_nss_i,
    input  logic                          spi_mosi_i,
    output logic                          spi_miso_o,
    output logic                          spi_miso_en_o,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count_o,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count_o,
    output logic                          busy_o,
    output logic                          rx_ovf_o,
    output logic                          tx_udf_o,
    output logic                          irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Handshakes: a push/pop takes effect on the clk_i edge where valid & ready are both high.

    // ---------------- input synchronisers ----------------
    logic [2:0] sck_q, nss_q;
    logic [1:0] mosi_q;
    logic       sck_rise, sck_fall, nss_fall, nss_rise, mosi_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_q  <= 3'b000;
            nss_q  <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], spi_sck_i};
            nss_q  <= {nss_q[1:0], spi_nss_i};
            mosi_q <= {mosi_q[0], spi_mosi_i};
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign nss_fall = ~nss_q[1] & nss_q[2];
    assign nss_rise = nss_q[1] & ~nss_q[2];
    assign mosi_s   = mosi_q[1];

    // ---------------- FIFO state ----------------
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
    logic [AW:0]   rx_cnt, tx_cnt;
    logic          rx_full, tx_full, rx_pop, rx_wr, tx_pop, tx_push;

    assign rx_full    = (rx_cnt == DEPTH_C);
    assign tx_full    = (tx_cnt == DEPTH_C);
    assign rx_valid_o = (rx_cnt != '0);
    assign tx_ready_o = ~tx_full;
    assign rx_count_o = rx_cnt;
    assign tx_count_o = tx_cnt;
    assign rx_data_o  = rx_valid_o ? rx_mem[rx_rd_ptr] : 8'h00;
    assign rx_pop     = rx_valid_o & rx_ready_i;
    assign tx_push    = tx_valid_i & (~tx_full | tx_pop);

    // ---------------- FSM registers ----------------
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic       miso_en_q, miso_en_d;
    logic       byte_seen_q, byte_seen_d;
    logic       ovf_q, udf_q, irq_q;
    logic       ovf_d, udf_d, irq_d;
    logic       load_tx, rx_push, frame_irq;
    logic [7:0] rx_byte;

    assign rx_byte = {rx_shift_q, mosi_s};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        miso_en_d   = miso_en_q;
        byte_seen_d = byte_seen_q;
        load_tx     = 1'b0;
        rx_push     = 1'b0;
        frame_irq   = 1'b0;
        tx_pop      = 1'b0;
        udf_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (nss_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = 3'd0;
                    miso_en_d = 1'b1;
                    load_tx   = 1'b1;
                end
            end
            SHIFT: begin
                // Deselect wins over a coincident SCK edge, so a closing SCK fall loads nothing.
                if (nss_rise) begin
                    state_d     = IDLE;
                    bit_cnt_d   = 3'd0;
                    miso_en_d   = 1'b0;
                    tx_shift_d  = 8'h00;
                    frame_irq   = byte_seen_q;
                    byte_seen_d = 1'b0;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_push     = 1'b1;
                        byte_seen_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q == 3'd0) load_tx = 1'b1;
                    else tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_tx) begin
            if (tx_cnt != '0) begin
                tx_shift_d = tx_mem[tx_rd_ptr];
                tx_pop     = 1'b1;
            end else begin
                tx_shift_d = 8'hFF;
                udf_d      = 1'b1;
            end
        end

        rx_wr = rx_push & (~rx_full | rx_pop);
        ovf_d = rx_push & ~rx_wr;
        irq_d = frame_irq | ovf_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            tx_shift_q  <= 8'h00;
            rx_shift_q  <= 7'h00;
            miso_en_q   <= 1'b0;
            byte_seen_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            miso_en_q   <= miso_en_d;
            byte_seen_q <= byte_seen_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            irq_q       <= irq_d;
        end
    end

    // tx_shift is cleared on deselect, so MISO stays low outside a frame.
    assign spi_miso_o    = miso_en_q & tx_shift_q[7];
    assign spi_miso_en_o = miso_en_q;
    assign busy_o        = (state_q == SHIFT);
    assign rx_ovf_o      = ovf_q;
    assign tx_udf_o      = udf_q;
    assign irq_o         = irq_q;

    // ---------------- FIFO pointers and storage ----------------
    always_ff @(posedge clk_i) begin
        if (rx_wr) rx_mem[rx_wr_ptr] <= rx_byte;
        if (tx_push) tx_mem[tx_wr_ptr] <= tx_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (rx_wr)   rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
            case ({rx_wr, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + (AW+1)'(1);
                2'b01:   rx_cnt <= rx_cnt - (AW+1)'(1);
                default: rx_cnt <= rx_cnt;
            endcase
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + (AW+1)'(1);
                2'b01:   tx_cnt <= tx_cnt - (AW+1)'(1);
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged mode-0 master, FIFO host driver,
// pulse counters, and immediate-assertion checks against hand-computed values.
module tb_spi_slave;

    localparam int HALF = 8;

    logic       clk, rst;
    logic       sck, nss, mosi;
    logic       miso, miso_en;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready;
    logic [3:0] rx_count, tx_count;
    logic       busy, rx_ovf, tx_udf, irq;

    int tests = 0;
    int fails = 0;
    int irq_cnt = 0, udf_cnt = 0, ovf_cnt = 0;
    int irq_base, udf_base, ovf_base;

    logic [7:0] mosi_bytes[$];
    logic [7:0] miso_bytes[$];

    spi_slave #(.FIFO_DEPTH(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .spi_sck_i(sck), .spi_nss_i(nss), .spi_mosi_i(mosi),
        .spi_miso_o(miso), .spi_miso_en_o(miso_en),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_count_o(rx_count), .tx_count_o(tx_count),
        .busy_o(busy), .rx_ovf_o(rx_ovf), .tx_udf_o(tx_udf), .irq_o(irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // pulse monitors
    always @(negedge clk) begin
        if (irq)    irq_cnt <= irq_cnt + 1;
        if (tx_udf) udf_cnt <= udf_cnt + 1;
        if (rx_ovf) ovf_cnt <= ovf_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic mark();
        tick(1);
        irq_base = irq_cnt;
        udf_base = udf_cnt;
        ovf_base = ovf_cnt;
    endtask

    // driver tasks
    task automatic push_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx(input string name, input logic [7:0] exp);
        check({name, "_valid"}, 32'(rx_valid), 1);
        check({name, "_data"}, 32'(rx_data), 32'(exp));
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    // Mode-0 master: MOSI set after SCK fall, MISO sampled just before SCK rise.
    // The closing SCK fall coincides with NSS rise.
    task automatic run_frame(input int nbits, input bit pop_last);
        logic [7:0] cur, cap;
        cur = 8'h00;
        cap = 8'h00;
        miso_bytes.delete();
        nss = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i % 8 == 0) cur = mosi_bytes[i / 8];
            mosi = cur[7 - (i % 8)];
            tick(HALF);
            if (i % 8 == 0) begin
                check("frame_miso_en", 32'(miso_en), 1);
                check("frame_busy", 32'(busy), 1);
            end
            cap = {cap[6:0], miso};
            sck = 1'b1;
            if (pop_last && i == nbits - 1) begin
                tick(2);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
                tick(HALF - 3);
            end else begin
                tick(HALF);
            end
            sck = 1'b0;
            if (i % 8 == 7) miso_bytes.push_back(cap);
        end
        nss  = 1'b1;
        mosi = 1'b0;
        tick(2 * HALF);
    endtask

    initial begin
        rst = 1'b1; sck = 1'b0; nss = 1'b1; mosi = 1'b0;
        rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        tick(3);
        rst = 1'b0;

        // reset state
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_tx_ready", 32'(tx_ready), 1);
        check("rst_rx_count", 32'(rx_count), 0);
        check("rst_tx_count", 32'(tx_count), 0);
        check("rst_miso", 32'(miso), 0);
        check("rst_miso_en", 32'(miso_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_irq", 32'(irq), 0);
        tick(4);

        // loopback byte
        push_tx(8'hA5);
        check("lb_tx_count", 32'(tx_count), 1);
        mark();
        mosi_bytes = '{8'h3C};
        run_frame(8, 1'b0);
        check("lb_miso", 32'(miso_bytes[0]), 'hA5);
        check("lb_rx_count", 32'(rx_count), 1);
        check("lb_irq", 32'(irq_cnt - irq_base), 1);
        check("lb_udf", 32'(udf_cnt - udf_base), 0);
        check("lb_tx_count_after", 32'(tx_count), 0);
        check("lb_miso_en_after", 32'(miso_en), 0);
        check("lb_busy_after", 32'(busy), 0);
        pop_rx("lb_rx", 8'h3C);
        check("lb_rx_empty", 32'(rx_valid), 0);

        // multi-byte frame
        push_tx(8'h01); push_tx(8'h02); push_tx(8'h03);
        mark();
        mosi_bytes = '{8'h11, 8'h22, 8'h33};
        run_frame(24, 1'b0);
        check("mb_miso0", 32'(miso_bytes[0]), 'h01);
        check("mb_miso1", 32'(miso_bytes[1]), 'h02);
        check("mb_miso2", 32'(miso_bytes[2]), 'h03);
        check("mb_rx_count", 32'(rx_count), 3);
        check("mb_irq", 32'(irq_cnt - irq_base), 1);
        check("mb_udf", 32'(udf_cnt - udf_base), 0);
        pop_rx("mb_rx0", 8'h11);
        pop_rx("mb_rx1", 8'h22);
        pop_rx("mb_rx2", 8'h33);

        // TX underflow
        mark();
        mosi_bytes = '{8'h81, 8'h7E};
        run_frame(16, 1'b0);
        check("udf_miso0", 32'(miso_bytes[0]), 'hFF);
        check("udf_miso1", 32'(miso_bytes[1]), 'hFF);
        check("udf_pulses", 32'(udf_cnt - udf_base), 2);
        pop_rx("udf_rx0", 8'h81);
        pop_rx("udf_rx1", 8'h7E);

        // RX overflow, no pop
        mark();
        mosi_bytes.delete();
        for (int i = 0; i < 9; i++) mosi_bytes.push_back(8'(i));
        run_frame(72, 1'b0);
        check("ovf_pulses", 32'(ovf_cnt - ovf_base), 1);
        check("ovf_irq", 32'(irq_cnt - irq_base), 2);
        check("ovf_rx_count", 32'(rx_count), 8);
        for (int i = 0; i < 8; i++) pop_rx("ovf_drain", 8'(i));
        check("ovf_rx_empty", 32'(rx_count), 0);

        // RX full with a pop coinciding with the 9th push
        mark();
        run_frame(72, 1'b1);
        check("ovfpop_pulses", 32'(ovf_cnt - ovf_base), 0);
        check("ovfpop_irq", 32'(irq_cnt - irq_base), 1);
        check("ovfpop_rx_count", 32'(rx_count), 8);
        for (int i = 1; i < 9; i++) pop_rx("ovfpop_drain", 8'(i));
        check("ovfpop_rx_empty", 32'(rx_count), 0);

        // aborted frame then a full one
        mark();
        mosi_bytes = '{8'hC7};
        run_frame(5, 1'b0);
        check("abort_rx_count", 32'(rx_count), 0);
        check("abort_irq", 32'(irq_cnt - irq_base), 0);
        check("abort_miso_en", 32'(miso_en), 0);
        check("abort_miso", 32'(miso), 0);
        mosi_bytes = '{8'h5A};
        run_frame(8, 1'b0);
        check("abort_next_count", 32'(rx_count), 1);
        pop_rx("abort_next_rx", 8'h5A);

        // reset mid-frame
        push_tx(8'hC3); push_tx(8'h96);
        mark();
        nss = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mosi = i[0];
            tick(HALF);
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
        end
        check("mid_tx_count_before", 32'(tx_count), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rx_count", 32'(rx_count), 0);
        check("mid_tx_count", 32'(tx_count), 0);
        check("mid_tx_ready", 32'(tx_ready), 1);
        check("mid_rx_valid", 32'(rx_valid), 0);
        check("mid_miso_en", 32'(miso_en), 0);
        check("mid_miso", 32'(miso), 0);
        check("mid_busy", 32'(busy), 0);
        tick(HALF);
        nss = 1'b1;
        tick(2 * HALF);
        check("mid_irq", 32'(irq_cnt - irq_base), 0);
        check("mid_busy_end", 32'(busy), 0);
        check("mid_rx_count_end", 32'(rx_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
